alu_writeback_regfile: RTL

Write-back stage and register file for the 8-bit single-cycle datapath. It sits directly downstream of the ALU, including the shift/rotate unit, and feeds both operand read ports back to the ALU. A one-entry pending-write register decouples ALU result capture from the array commit. An optional bypass path keeps reads coherent during that one-cycle window.

---
 rtl/alu_writeback_regfile_pkg.sv | 7 +
 rtl/alu_writeback_regfile_pending.sv | 38 +++
 rtl/alu_writeback_regfile.sv | 66 ++++++
 3 files changed

// File: rtl/alu_writeback_regfile_pkg.sv
// alu_writeback_regfile_pkg: shared widths and reset value for the write-back stage.
package alu_writeback_regfile_pkg;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 3;
   localparam int DEF_NREGS  = 2 ** DEF_ADDR_W;
   localparam logic [DEF_DATA_W-1:0] RST_VAL = '0;
endpackage

// File: rtl/alu_writeback_regfile_pending.sv
// wb_pending_reg: one-entry pending-write register between ALU capture and array commit.
module wb_pending_reg
   import alu_writeback_regfile_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              capture_en,
   input  logic [ADDR_W-1:0] capture_addr,
   input  logic [DATA_W-1:0] capture_data,
   output logic              pend_valid,
   output logic [ADDR_W-1:0] pend_addr,
   output logic [DATA_W-1:0] pend_data
);
   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   always_comb begin
      valid_d = capture_en;
      addr_d  = capture_addr;
      data_d  = capture_data;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= DATA_W'(RST_VAL);
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   assign pend_valid = valid_q;
   assign pend_addr  = addr_q;
   assign pend_data  = data_q;
endmodule

// File: rtl/alu_writeback_regfile.sv
// alu_writeback_regfile: write-back stage and register file with a one-entry pending write.
// ALU_WB_BYPASS_EN forwards the pending write to the read ports; otherwise HAZARDx flags it.
module alu_writeback_regfile
   import alu_writeback_regfile_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int NREGS  = DEF_NREGS,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              WRITEENABLE,
   input  logic [ADDR_W-1:0] WRITEREG,
   input  logic [DATA_W-1:0] WRITEDATA,
   input  logic [ADDR_W-1:0] READREG1,
   input  logic [ADDR_W-1:0] READREG2,
   output logic [DATA_W-1:0] REGOUT1,
   output logic [DATA_W-1:0] REGOUT2,
   output logic              PENDING,
   output logic              HAZARD1,
   output logic              HAZARD2
);
   logic              pend_valid;
   logic [ADDR_W-1:0] pend_addr;
   logic [DATA_W-1:0] pend_data;
   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];
   logic              hit1, hit2;

   wb_pending_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_pend (
      .clk          (CLK),
      .rst_n        (RESET_N),
      .capture_en   (WRITEENABLE),
      .capture_addr (WRITEREG),
      .capture_data (WRITEDATA),
      .pend_valid   (pend_valid),
      .pend_addr    (pend_addr),
      .pend_data    (pend_data)
   );

   // Commit the older entry on the same edge the newer one is captured.
   always_comb begin
      regs_d = regs_q;
      if (pend_valid) regs_d[pend_addr] = pend_data;
   end

   always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) regs_q <= '{default: DATA_W'(RST_VAL)};
      else          regs_q <= regs_d;

   assign hit1    = pend_valid && (READREG1 == pend_addr);
   assign hit2    = pend_valid && (READREG2 == pend_addr);
   assign PENDING = pend_valid;

`ifdef ALU_WB_BYPASS_EN
   assign REGOUT1 = hit1 ? pend_data : regs_q[READREG1];
   assign REGOUT2 = hit2 ? pend_data : regs_q[READREG2];
   assign HAZARD1 = 1'b0;
   assign HAZARD2 = 1'b0;
`else
   assign REGOUT1 = regs_q[READREG1];
   assign REGOUT2 = regs_q[READREG2];
   assign HAZARD1 = hit1;
   assign HAZARD2 = hit2;
`endif
endmodule
